// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the DMEM port-B arbiter: response owner and halt FSM encodings,
// plus the small decode helpers used by the arbiter.
package dmem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Who gets the read data returned by the BRAM on the following cycle.
  function automatic owner_e read_owner(input logic            core_gnt,
                                        input logic [WE_W-1:0] core_we,
                                        input logic            dbg_gnt,
                                        input logic [WE_W-1:0] dbg_we);
    owner_e owner;
    owner = OWN_NONE;
    if (core_gnt && (core_we == '0)) owner = OWN_CORE;
    else if (dbg_gnt && (dbg_we == '0)) owner = OWN_DBG;
    return owner;
  endfunction

  // Byte-lane merge for a write-enabled word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [WE_W-1:0]   we);
    logic [DATA_W-1:0] word;
    word = old_word;
    for (int b = 0; b < WE_W; b++) begin
      if (we[b]) word[8*b +: 8] = new_word[8*b +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, debug and BRAM port-B signals around the DMEM arbiter.
// The arbiter takes the slave view; the surrounding pipeline/loader/BRAM take the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 13
);

  logic              core_req;
  logic [3:0]        core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_stall;
  logic [31:0]       core_rdata;

  logic              dbg_halt;
  logic              dbg_req;
  logic [3:0]        dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              halted;

  logic [3:0]        web;
  logic [ADDR_W-1:0] addrb;
  logic [31:0]       dib;
  logic [31:0]       dob;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dob,
    input  core_stall, core_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, halted,
    input  web, addrb, dib
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dob,
    output core_stall, core_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, halted,
    output web, addrb, dib
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares BRAM port B between the core MEM stage (priority) and a debug/loader master,
// with a starvation guarantee for debug and a halt FSM giving debug exclusive ownership.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e             state;
  logic               halted_q;
  logic               hold_q;
  owner_e             rsp_owner;
  logic [CNT_W-1:0]   starve_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  core_rdata_q;

  logic               core_gnt;
  logic               dbg_gnt;
  logic               starved;
  logic [WE_W-1:0]    port_we;
  logic [ADDR_W-1:0]  port_addr;
  logic [DATA_W-1:0]  port_wdata;
  logic [DATA_W-1:0]  core_rdata;

  // Same-cycle grant. Nothing is granted while reset is asserted so no BRAM write escapes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    starved  = bus.dbg_req && (starve_cnt == STARVE_LIM);
    case (state)
      ST_RUN: begin
        core_gnt = bus.core_req && !starved;
        dbg_gnt  = bus.dbg_req && !core_gnt;
      end
      ST_DRAIN, ST_HALTED: dbg_gnt = bus.dbg_req;
      default: ;
    endcase
    if (rst) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
    end
  end

  // Granted master drives the port; otherwise address/data hold and writes are off.
  always_comb begin
    port_we    = '0;
    port_addr  = addr_q;
    port_wdata = wdata_q;
    if (core_gnt) begin
      port_we    = bus.core_we;
      port_addr  = bus.core_addr;
      port_wdata = bus.core_wdata;
    end else if (dbg_gnt) begin
      port_we    = bus.dbg_we;
      port_addr  = bus.dbg_addr;
      port_wdata = bus.dbg_wdata;
    end
  end

  // Halt FSM. DRAIN lasts one cycle so a core read granted just before the halt can return.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.dbg_halt) begin
            state  <= ST_DRAIN;
            hold_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.dbg_halt) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            state  <= ST_RUN;
            hold_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (!bus.dbg_halt) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            hold_q   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
          hold_q   <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter and read-response ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rsp_owner  <= OWN_NONE;
    end else begin
      if (bus.dbg_req && !dbg_gnt) begin
        starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      rsp_owner <= read_owner(core_gnt, bus.core_we, dbg_gnt, bus.dbg_we);
    end
  end

  // Core read data is passed through on its return cycle and held afterwards.
  assign core_rdata = ((rsp_owner == OWN_CORE) && !rst) ? bus.dob : core_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
    end else begin
      if (core_gnt || dbg_gnt) begin
        addr_q  <= port_addr;
        wdata_q <= port_wdata;
      end
      core_rdata_q <= core_rdata;
    end
  end

  assign bus.web        = port_we;
  assign bus.addrb      = port_addr;
  assign bus.dib        = port_wdata;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.core_stall = (bus.core_req && !core_gnt) || hold_q;
  assign bus.core_rdata = core_rdata;
  assign bus.dbg_rvalid = (rsp_owner == OWN_DBG) && !rst;
  assign bus.dbg_rdata  = bus.dob;
  assign bus.halted     = halted_q;

endmodule
